// File: rtl/led_bar_counter_if.sv
// ============================================================================
// Module      : led_bar_counter_if
// Description : Button, clear and count/flag bundle for the LED bar counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_bar_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       clear;
    logic [4:0] current_count;
    logic       at_max;
    logic       at_min;

    modport master (
        output btn_up,
        output btn_down,
        output clear,
        input  current_count,
        input  at_max,
        input  at_min
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        input  clear,
        output current_count,
        output at_max,
        output at_min
    );
endinterface

`default_nettype wire

// File: rtl/led_bar_counter.sv
// ============================================================================
// Module      : led_bar_counter
// Description : Debounced up/down push-button counter with saturation flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_bar_counter #(
    parameter int DB_CYCLES = 20,
    parameter int MAX_COUNT = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    led_bar_counter_if.slave  bus
);

    localparam int               C_TW   = $clog2(DB_CYCLES);
    localparam logic [C_TW-1:0]  C_TMAX = C_TW'(DB_CYCLES - 1);
    localparam logic [4:0]       C_MAX  = 5'(MAX_COUNT);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } db_state_t;

    logic [1:0] w_raw;
    logic [1:0] w_step;
    logic [4:0] r_count;

    assign w_raw = {bus.btn_down, bus.btn_up};

    // Bit 0 is the up button, bit 1 the down button.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_db
            logic [1:0]      r_sync;
            db_state_t       r_state;
            logic [C_TW-1:0] r_timer;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync  <= 2'b00;
                    r_state <= RELEASED;
                    r_timer <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_raw[g]};
                    case (r_state)
                        RELEASED: begin
                            if (r_sync[1]) begin
                                r_state <= PRESS_CHK;
                                r_timer <= '0;
                            end
                        end
                        PRESS_CHK: begin
                            if (!r_sync[1])
                                r_state <= RELEASED;
                            else if (r_timer == C_TMAX)
                                r_state <= HELD;
                            else
                                r_timer <= r_timer + C_TW'(1);
                        end
                        HELD: begin
                            if (!r_sync[1]) begin
                                r_state <= RELEASE_CHK;
                                r_timer <= '0;
                            end
                        end
                        RELEASE_CHK: begin
                            if (r_sync[1])
                                r_state <= HELD;
                            else if (r_timer == C_TMAX)
                                r_state <= RELEASED;
                            else
                                r_timer <= r_timer + C_TW'(1);
                        end
                        default: r_state <= RELEASED;
                    endcase
                end
            end

            // The step fires on the same edge that moves PRESS_CHK into HELD.
            assign w_step[g] = (r_state == PRESS_CHK) && r_sync[1] && (r_timer == C_TMAX);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_count <= 5'd0;
        end else begin
            case (w_step)
                2'b01:   if (r_count != C_MAX) r_count <= r_count + 5'd1;
                2'b10:   if (r_count != 5'd0)  r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.current_count = r_count;
    assign bus.at_max        = (r_count == C_MAX);
    assign bus.at_min        = (r_count == 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_led_bar_counter.sv
// ============================================================================
// Module      : tb_led_bar_counter
// Description : Randomised and directed bench against a stable-run reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_bar_counter;

    localparam int DB   = 4;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_bar_counter_if bus ();

    led_bar_counter #(
        .DB_CYCLES (DB),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: a button's accepted level flips once the synchronised input
    // has disagreed with it for DB+1 consecutive edges; a flip to 1 is a step.
    int m_count = 0;
    bit m_acc [2];
    int m_run [2];
    bit [1:0] m_hist [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit raw [2];
        bit pulse [2];
        bit s;
        raw[0] = bus.btn_up;
        raw[1] = bus.btn_down;
        if (rst) begin
            m_count = 0;
            for (int b = 0; b < 2; b++) begin
                m_acc[b] = 0; m_run[b] = 0; m_hist[b] = 2'b00;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                pulse[b] = 0;
                s = m_hist[b][1];
                if (s != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB + 1) begin
                        m_acc[b] = s;
                        m_run[b] = 0;
                        pulse[b] = s;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_hist[b] = {m_hist[b][0], raw[b]};
            end
            if (bus.clear)                    m_count = 0;
            else if (pulse[0] && pulse[1])    m_count = m_count;
            else if (pulse[0] && m_count < MAXC) m_count = m_count + 1;
            else if (pulse[1] && m_count > 0)    m_count = m_count - 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("count",  int'(bus.current_count), m_count);
        check("at_max", int'(bus.at_max), int'(m_count == MAXC));
        check("at_min", int'(bus.at_min), int'(m_count == 0));
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // which: 0 = up, 1 = down, 2 = both together
    task automatic press(input int which);
        if (which != 1) bus.btn_up   = 1'b1;
        if (which != 0) bus.btn_down = 1'b1;
        cycles(8);
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        cycles(8);
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.clear = 1'b0;
        cycles(2);
        check("rst_count",  int'(bus.current_count), 0);
        check("rst_at_min", int'(bus.at_min), 1);
        check("rst_at_max", int'(bus.at_max), 0);
        rst = 1'b0;

        // Press latency and hold without auto-repeat
        bus.btn_up = 1'b1;
        cycles(6);
        check("lat_edge6", int'(bus.current_count), 0);
        cyc();
        check("lat_edge7", int'(bus.current_count), 1);
        check("lat_at_min", int'(bus.at_min), 0);
        cycles(13);
        check("no_repeat", int'(bus.current_count), 1);
        bus.btn_up = 1'b0;
        cycles(8);

        // Short glitch is ignored
        bus.btn_up = 1'b1;
        cycles(3);
        bus.btn_up = 1'b0;
        cycles(10);
        check("glitch", int'(bus.current_count), 1);

        // Saturation at the top, then one step down
        do_reset();
        for (int i = 0; i < 16; i++) press(0);
        check("reach_max", int'(bus.current_count), 16);
        press(0);
        check("sat_max", int'(bus.current_count), 16);
        check("sat_at_max", int'(bus.at_max), 1);
        press(1);
        check("down_from_max", int'(bus.current_count), 15);

        // Saturation at zero, simultaneous presses
        do_reset();
        press(1);
        check("sat_min", int'(bus.current_count), 0);
        check("sat_at_min", int'(bus.at_min), 1);
        press(0);
        press(2);
        check("both_press", int'(bus.current_count), 1);

        // Clear coincident with an up step
        do_reset();
        for (int i = 0; i < 9; i++) press(0);
        check("count9", int'(bus.current_count), 9);
        bus.btn_up = 1'b1;
        cycles(6);
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        check("clear_wins", int'(bus.current_count), 0);
        cycles(10);
        bus.btn_up = 1'b0;
        cycles(8);
        check("clear_no_late", int'(bus.current_count), 0);

        // Reset during PRESS_CHK with the button held throughout
        do_reset();
        bus.btn_up = 1'b1;
        cycles(4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_count", int'(bus.current_count), 0);
        cycles(6);
        check("midrst_edge6", int'(bus.current_count), 0);
        cyc();
        check("midrst_edge7", int'(bus.current_count), 1);
        bus.btn_up = 1'b0;
        cycles(8);

        // Random toggling against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.btn_up   = ~bus.btn_up;
            if ($urandom_range(0, 7) == 0) bus.btn_down = ~bus.btn_down;
            bus.clear = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        bus.clear = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
